// File: rtl/simmem_release_scheduler.sv
// Per-ID release scheduler: one countdown slot per stored transaction; ripe slots raise release_en for their ID.
// Latency: release_en rises two cycles plus the delay after enqueue; all outputs come straight from flops.
module simmem_release_scheduler #(
  parameter int IDWidth    = 4,
  parameter int NumSlots   = 16,
  parameter int DelayWidth = 8,
  localparam int CntWidth     = $clog2(NumSlots + 1),
  localparam int SlotIdxWidth = $clog2(NumSlots),
  localparam int NumIds       = 2 ** IDWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enq_valid_i,
  output logic                  enq_ready_o,
  input  logic [IDWidth-1:0]    enq_id_i,
  input  logic [DelayWidth-1:0] enq_delay_i,
  output logic [NumIds-1:0]     release_en_o,
  input  logic                  rel_valid_i,
  input  logic [IDWidth-1:0]    rel_id_i,
  output logic [CntWidth-1:0]   free_slots_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_COUNTING = 2'd1,
    SLOT_RIPE     = 2'd2
  } slot_state_e;

  slot_state_e           state_q    [NumSlots];
  slot_state_e           state_d    [NumSlots];
  logic [IDWidth-1:0]    id_q       [NumSlots];
  logic [IDWidth-1:0]    id_d       [NumSlots];
  logic [DelayWidth-1:0] cnt_q      [NumSlots];
  logic [DelayWidth-1:0] cnt_d      [NumSlots];
  logic [CntWidth-1:0]   ripe_cnt_q [NumIds];
  logic [CntWidth-1:0]   ripe_cnt_d [NumIds];

  logic [CntWidth-1:0]     free_slots_q, free_slots_d;
  logic [NumIds-1:0]       release_en_q, release_en_d;
  logic                    enq_ready_q;
  logic                    err_q;
  logic                    alloc_found, rel_hit;
  logic [SlotIdxWidth-1:0] alloc_idx, rel_idx;
  logic                    enq_fire, rel_ok, rel_fire, rel_bad;

  // Lowest-index FREE slot for allocation, lowest-index RIPE slot of rel_id_i for retirement.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    rel_hit     = 1'b0;
    rel_idx     = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!alloc_found && state_q[s] == SLOT_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = SlotIdxWidth'(s);
      end
      if (!rel_hit && state_q[s] == SLOT_RIPE && id_q[s] == rel_id_i) begin
        rel_hit = 1'b1;
        rel_idx = SlotIdxWidth'(s);
      end
    end
  end

  assign enq_fire = enq_valid_i && enq_ready_q && alloc_found;
  assign rel_ok   = rel_valid_i && (ripe_cnt_q[rel_id_i] != '0);
  assign rel_fire = rel_ok && rel_hit;
  assign rel_bad  = rel_valid_i && (ripe_cnt_q[rel_id_i] == '0);

  always_comb begin
    for (int s = 0; s < NumSlots; s++) begin
      state_d[s] = state_q[s];
      id_d[s]    = id_q[s];
      cnt_d[s]   = cnt_q[s];
      if (state_q[s] == SLOT_COUNTING) begin
        if (cnt_q[s] == '0) begin
          state_d[s] = SLOT_RIPE;
        end else begin
          cnt_d[s] = cnt_q[s] - DelayWidth'(1);
        end
      end
      if (enq_fire && alloc_idx == SlotIdxWidth'(s)) begin
        state_d[s] = SLOT_COUNTING;
        id_d[s]    = enq_id_i;
        cnt_d[s]   = enq_delay_i;
      end
      if (rel_fire && rel_idx == SlotIdxWidth'(s)) begin
        state_d[s] = SLOT_FREE;
      end
    end
  end

  // Per-ID popcount of slots ripening this cycle, minus at most one retirement.
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      ripe_cnt_d[i] = ripe_cnt_q[i];
    end
    for (int s = 0; s < NumSlots; s++) begin
      if (state_q[s] == SLOT_COUNTING && cnt_q[s] == '0) begin
        ripe_cnt_d[id_q[s]] = ripe_cnt_d[id_q[s]] + CntWidth'(1);
      end
    end
    if (rel_fire) begin
      ripe_cnt_d[rel_id_i] = ripe_cnt_d[rel_id_i] - CntWidth'(1);
    end
    for (int i = 0; i < NumIds; i++) begin
      release_en_d[i] = (ripe_cnt_d[i] != '0);
    end
  end

  assign free_slots_d = free_slots_q - CntWidth'(enq_fire) + CntWidth'(rel_fire);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSlots; s++) begin
        state_q[s] <= SLOT_FREE;
        id_q[s]    <= '0;
        cnt_q[s]   <= '0;
      end
      for (int i = 0; i < NumIds; i++) begin
        ripe_cnt_q[i] <= '0;
      end
      free_slots_q <= CntWidth'(NumSlots);
      release_en_q <= '0;
      enq_ready_q  <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      for (int s = 0; s < NumSlots; s++) begin
        state_q[s] <= state_d[s];
        id_q[s]    <= id_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      for (int i = 0; i < NumIds; i++) begin
        ripe_cnt_q[i] <= ripe_cnt_d[i];
      end
      free_slots_q <= free_slots_d;
      release_en_q <= release_en_d;
      enq_ready_q  <= (free_slots_d != '0);
      err_q        <= err_q | rel_bad;
    end
  end

  assign enq_ready_o  = enq_ready_q;
  assign release_en_o = release_en_q;
  assign free_slots_o = free_slots_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Randomized and directed bench for simmem_release_scheduler against a due-time transaction model.
module tb_simmem_release_scheduler;
  localparam int NS = 16;
  localparam int NI = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [3:0]  enq_id = '0;
  logic [7:0]  enq_delay = '0;
  logic [15:0] release_en;
  logic        rel_valid = 1'b0;
  logic [3:0]  rel_id = '0;
  logic [4:0]  free_slots;
  logic        err;

  always #5 clk = ~clk;

  simmem_release_scheduler #(.IDWidth(4), .NumSlots(NS), .DelayWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_id_i(enq_id), .enq_delay_i(enq_delay),
    .release_en_o(release_en),
    .rel_valid_i(rel_valid), .rel_id_i(rel_id),
    .free_slots_o(free_slots), .err_o(err)
  );

  // Each outstanding transaction is ripe from cycle 'due' = enqueue cycle + 2 + delay.
  typedef struct {int id; int due;} txn_t;
  txn_t pend[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   m_err = 1'b0;
  bit   checks_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int ripe(input int id);
    int n = 0;
    foreach (pend[k]) if (pend[k].id == id && pend[k].due <= cyc) n++;
    return n;
  endfunction

  task automatic step(input bit ev, input int eid, input int ed,
                      input bit rv, input int rid, input bit rstn);
    logic [15:0] exp_en;
    bit acc;
    @(negedge clk);
    if (checks_on) begin
      for (int i = 0; i < NI; i++) exp_en[i] = (ripe(i) > 0);
      chk("release_en", 32'(release_en), 32'(exp_en));
      chk("free_slots", 32'(free_slots), 32'(NS - pend.size()));
      chk("enq_ready", 32'(enq_ready), 32'(pend.size() < NS));
      chk("err", 32'(err), 32'(m_err));
    end
    rst_n     = rstn;
    enq_valid = ev;
    enq_id    = eid[3:0];
    enq_delay = ed[7:0];
    rel_valid = rv;
    rel_id    = rid[3:0];
    @(posedge clk);
    if (!rstn) begin
      pend.delete();
      m_err = 1'b0;
    end else begin
      acc = ev && (pend.size() < NS);
      if (rv) begin
        if (ripe(rid) > 0) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == rid && pend[k].due <= cyc) begin
              pend.delete(k);
              break;
            end
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (acc) pend.push_back('{id: eid, due: cyc + 2 + ed});
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ids[$];
    int rid;
    bit rv;
    do_reset();
    checks_on = 1'b1;

    // Single transaction: id 3, delay 5, released once ripe.
    idle(8);
    step(1, 3, 5, 0, 0, 1);
    idle(9);
    step(0, 0, 0, 1, 3, 1);
    idle(3);

    // Fill to full with long delays, one extra enqueue, then retire the first.
    for (int i = 0; i < NS; i++) step(1, i, 255, 0, 0, 1);
    step(1, 4, 3, 0, 0, 1);
    idle(257);
    step(0, 0, 0, 1, 0, 1);
    step(1, 6, 1, 0, 0, 1);
    idle(4);
    do_reset();

    // Same ID with out-of-order delays.
    step(1, 1, 20, 0, 0, 1);
    step(1, 1, 2, 0, 0, 1);
    idle(5);
    step(0, 0, 0, 1, 1, 1);
    idle(18);
    step(0, 0, 0, 1, 1, 1);
    idle(3);
    do_reset();

    // Two IDs ripen as id 2 is released, while id 7 is enqueued.
    step(1, 2, 0, 0, 0, 1);
    step(1, 2, 3, 0, 0, 1);
    step(1, 5, 2, 0, 0, 1);
    idle(2);
    step(1, 7, 9, 1, 2, 1);
    idle(3);
    step(0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 1, 5, 1);
    idle(12);
    step(0, 0, 0, 1, 7, 1);
    idle(2);

    // Randomized traffic; releases only of IDs the model says are ripe.
    for (int c = 0; c < 2500; c++) begin
      ids.delete();
      for (int i = 0; i < NI; i++) if (ripe(i) > 0) ids.push_back(i);
      rv  = (ids.size() > 0) && ($urandom_range(0, 99) < 55);
      rid = rv ? ids[$urandom_range(0, ids.size() - 1)] : 0;
      step($urandom_range(0, 99) < 45, $urandom_range(0, 15),
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12),
           rv, rid, 1);
    end
    do_reset();

    // Spurious release sets the sticky error without touching other state.
    step(1, 4, 1, 0, 0, 1);
    step(0, 0, 0, 1, 9, 1);
    idle(3);
    step(0, 0, 0, 1, 4, 1);
    idle(3);

    // Reset with eight slots counting.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, i, 10 + i, 0, 0, 1);
    idle(3);
    do_reset();
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
